// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// Optional BIN_TO_BCD_SAT_EN: saturate bcd_out to all 9s on overflow.
module bin_to_bcd_seq #(
  parameter int N = 4,
  parameter int W = 4 * N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   bin_in,
  output logic           busy,
  output logic           done,
  output logic [4*N-1:0] bcd_out,
  output logic           overflow
);

  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * N;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]  sh;
  logic [BW-1:0] bcd;
  logic          ovf;
  logic [CW-1:0] cnt;

  logic [BW-1:0] adj;
  logic [BW-1:0] bcd_sh;
  logic          carry;
  logic          accept;
  logic          step;
  logic          finish;

  assign accept = (state == IDLE) && start;
  assign step   = (state == CONVERT) && (cnt != '0);
  assign finish = (state == CONVERT) && (cnt == '0);

  // Add-3 correction on every digit that would overflow when doubled.
  always_comb begin
    adj = bcd;
    for (int k = 0; k < N; k++) begin
      if (bcd[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  // Shift the corrected digits left; the binary MSB feeds digit 0.
  always_comb begin
    carry  = adj[BW-1];
    bcd_sh = {adj[BW-2:0], sh[W-1]};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state: the extra zero-count cycle registers the result.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CONVERT;
      CONVERT: if (cnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Working registers: load on accept, one iteration per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      bcd <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      sh  <= bin_in;
      bcd <= '0;
      ovf <= 1'b0;
      cnt <= CW'(W);
    end else if (step) begin
      sh  <= sh << 1;
      bcd <= bcd_sh;
      ovf <= ovf | carry;
      cnt <= cnt - CW'(1);
    end
  end

  // Result registers update on the edge entering DONE and hold after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else if (finish) begin
      overflow <= ovf;
`ifdef BIN_TO_BCD_SAT_EN
      bcd_out  <= ovf ? {N{4'h9}} : bcd;
`else
      bcd_out  <= bcd;
`endif
    end
  end

  assign busy = (state == CONVERT) || (state == DONE);
  assign done = (state == DONE);

endmodule
